// File: rtl/pedest_btn_conditioner_if.sv
// ---------------------------------------------------------------------------
// pedest_btn_conditioner_if
// Purpose : groups the pedestrian button conditioner's pin-side inputs and
//           conditioned outputs into one bundle.
// Signals :
//   btn_pin     raw asynchronous button pin (polarity set by ACTIVE_LOW)
//   clr_count   one-cycle request to zero press_count
//   button      debounced level, 1 = pressed
//   press_pulse one-cycle pulse when a press is accepted
//   press_count accepted presses, modulo 256
//   long_press  one-cycle pulse on a long hold (0 unless PB_LONG_PRESS_EN)
//   dbg_state   current debounce state, for observation only
// Handshake: there is no valid/ready pair. btn_pin is a free-running level,
//   clr_count is a single-cycle strobe sampled on every rising clk edge, and
//   all outputs are registered levels/pulses that are valid every cycle.
// Modports: master = stimulus/consumer side, slave = conditioner side.
// ---------------------------------------------------------------------------
interface pedest_btn_conditioner_if;
   logic       btn_pin;
   logic       clr_count;
   logic       button;
   logic       press_pulse;
   logic [7:0] press_count;
   logic       long_press;
   logic [1:0] dbg_state;

   modport master (
      output btn_pin,
      output clr_count,
      input  button,
      input  press_pulse,
      input  press_count,
      input  long_press,
      input  dbg_state
   );

   modport slave (
      input  btn_pin,
      input  clr_count,
      output button,
      output press_pulse,
      output press_count,
      output long_press,
      output dbg_state
   );
endinterface

// File: rtl/pedest_btn_conditioner.sv
// ---------------------------------------------------------------------------
// pedest_btn_conditioner
// Purpose : turns the raw pedestrian push-button pin into a clean debounced
//           'button' level, a one-cycle press pulse and a modulo-256 press
//           counter. Both press and release edges are debounced.
// Ports   :
//   clk  in  system clock
//   rst  in  synchronous reset, active high
//   bus  pedest_btn_conditioner_if.slave
//        btn_pin, clr_count in; button, press_pulse, press_count,
//        long_press, dbg_state out
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept an edge (min 2)
//   ACTIVE_LOW       1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//   LONG_CYCLES      hold time for a long press (min 2)
// Build option:
//   PB_LONG_PRESS_EN  when defined, long_press pulses once per press after
//                     LONG_CYCLES cycles in the pressed states; otherwise
//                     long_press is constant 0. Ports are identical.
// All outputs are registered; no combinational input-to-output path.
// ---------------------------------------------------------------------------
module pedest_btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1,
   parameter int LONG_CYCLES     = 50000000
) (
   input logic                     clk,
   input logic                     rst,
   pedest_btn_conditioner_if.slave bus
);

   localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   // Pin level that means "not pressed"; the sync flops reset to it.
   localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      PRESSED   = 2'd2,
      RELEASING = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [DW-1:0] r_deb_cnt;
   logic [DW-1:0] w_next_cnt;
   logic          w_accept;
   logic          w_raw_s;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_button;
   logic          r_press_pulse;
   logic [7:0]    r_press_count;

   // Polarity-normalised synchronised pin: 1 = pressed.
   assign w_raw_s = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_deb_cnt;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            w_next_cnt = '0;
            if (w_raw_s) begin
               w_next_state = ARMING;
               w_next_cnt   = DW'(1);
            end
         end
         ARMING: begin
            if (!w_raw_s) begin
               w_next_state = IDLE;
               w_next_cnt   = '0;
            end else if (r_deb_cnt == DEB_LAST) begin
               w_next_state = PRESSED;
               w_next_cnt   = '0;
               w_accept     = 1'b1;
            end else begin
               w_next_cnt = r_deb_cnt + DW'(1);
            end
         end
         PRESSED: begin
            if (!w_raw_s) begin
               w_next_state = RELEASING;
               w_next_cnt   = DW'(1);
            end
         end
         RELEASING: begin
            if (w_raw_s) begin
               // Release bounce: back to PRESSED without a new pulse.
               w_next_state = PRESSED;
               w_next_cnt   = '0;
            end else if (r_deb_cnt == DEB_LAST) begin
               w_next_state = IDLE;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt = r_deb_cnt + DW'(1);
            end
         end
         default: begin
            w_next_state = IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_deb_cnt     <= '0;
         r_sync1       <= PIN_IDLE;
         r_sync2       <= PIN_IDLE;
         r_button      <= 1'b0;
         r_press_pulse <= 1'b0;
         r_press_count <= 8'd0;
      end else begin
         r_state       <= w_next_state;
         r_deb_cnt     <= w_next_cnt;
         r_sync1       <= bus.btn_pin;
         r_sync2       <= r_sync1;
         r_button      <= (w_next_state == PRESSED) || (w_next_state == RELEASING);
         r_press_pulse <= w_accept;
         // A clear coinciding with an accepted press clears first, then counts.
         if (w_accept) begin
            r_press_count <= bus.clr_count ? 8'd1 : (r_press_count + 8'd1);
         end else if (bus.clr_count) begin
            r_press_count <= 8'd0;
         end
      end
   end

   assign bus.button      = r_button;
   assign bus.press_pulse = r_press_pulse;
   assign bus.press_count = r_press_count;
   assign bus.dbg_state   = r_state;

`ifdef PB_LONG_PRESS_EN
   localparam int HW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] r_hold_cnt;
   logic          r_long_done;
   logic          r_long_press;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_cnt   <= '0;
         r_long_done  <= 1'b0;
         r_long_press <= 1'b0;
      end else begin
         r_long_press <= 1'b0;
         // Count through release bounces; saturate so the pulse fires once.
         if ((r_state == PRESSED) || (r_state == RELEASING)) begin
            if (r_hold_cnt != HOLD_LAST) begin
               r_hold_cnt <= r_hold_cnt + HW'(1);
            end else if (!r_long_done) begin
               r_long_press <= 1'b1;
               r_long_done  <= 1'b1;
            end
         end
         // Entry to IDLE ends the press and rearms the long-press detector.
         if (w_next_state == IDLE) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
         end
      end
   end

   assign bus.long_press = r_long_press;
`else
   // Constant 0; the comparison is always false and keeps LONG_CYCLES referenced.
   assign bus.long_press = (LONG_CYCLES < 0);
`endif

endmodule
